load_store_unit: RTL and testbench

- Memory-side initiator that drives DataMemory (Address, WriteData, MemWrite, MemRead, ReadData) on behalf of the datapath.
- Executes one sub-word or word load/store per request; byte/halfword stores are done as a read-modify-write.
- Sits between the EX/MEM stage and DataMemory; stalls the pipeline via Busy.

---
 rtl/load_store_unit_pkg.sv | 41 ++++
 rtl/load_store_unit_if.sv | 29 ++
 rtl/load_store_unit_byte_lane_unit.sv | 36 +++
 rtl/load_store_unit.sv | 108 ++++++++++
 tb/tb_load_store_unit.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared types for the load/store unit: op encodings, FSM states and decode helpers.
package load_store_unit_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [3:0] {
    OpLb  = 4'b0000,
    OpLh  = 4'b0001,
    OpLw  = 4'b0010,
    OpLbu = 4'b0100,
    OpLhu = 4'b0101,
    OpSb  = 4'b1000,
    OpSh  = 4'b1001,
    OpSw  = 4'b1010
  } op_e;

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StRmwRd,
    StWrite,
    StResp
  } state_e;

  function automatic logic op_legal(input logic [3:0] op);
    case (op)
      OpLb, OpLh, OpLw, OpLbu, OpLhu, OpSb, OpSh, OpSw: return 1'b1;
      default:                                          return 1'b0;
    endcase
  endfunction

  function automatic logic op_misaligned(input logic [3:0] op, input logic [1:0] lane);
    case (op)
      OpLh, OpLhu, OpSh: return lane[0];
      OpLw, OpSw:        return |lane;
      default:           return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Request and DataMemory signals of the load/store unit, with LSU (slave) and driver (master) views.
interface load_store_unit_if;
  import load_store_unit_pkg::*;

  logic              Start;
  logic [3:0]        Op;
  logic [ADDR_W-1:0] Addr;
  logic [DATA_W-1:0] StoreData;
  logic [DATA_W-1:0] LoadData;
  logic              Done;
  logic              Error;
  logic              Busy;
  logic [ADDR_W-1:0] MemAddress;
  logic [DATA_W-1:0] MemWriteData;
  logic              MemWrite;
  logic              MemRead;
  logic [DATA_W-1:0] MemReadData;

  modport slave (
    input  Start, Op, Addr, StoreData, MemReadData,
    output LoadData, Done, Error, Busy, MemAddress, MemWriteData, MemWrite, MemRead
  );

  modport master (
    output Start, Op, Addr, StoreData, MemReadData,
    input  LoadData, Done, Error, Busy, MemAddress, MemWriteData, MemWrite, MemRead
  );

endinterface

// File: rtl/load_store_unit_byte_lane_unit.sv
// Little-endian lane logic: extends a loaded byte/half and merges a byte/half into a word.
module byte_lane_unit
  import load_store_unit_pkg::*;
(
  input  logic [DATA_W-1:0] word_i,
  input  logic [1:0]        addr_i,
  input  logic [3:0]        op_i,
  input  logic [15:0]       store_data_i,
  output logic [DATA_W-1:0] load_value_o,
  output logic [DATA_W-1:0] store_word_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word_i[{addr_i, 3'b000} +: 8];
    half_sel = word_i[{addr_i[1], 4'b0000} +: 16];

    case (op_i)
      OpLb:    load_value_o = {{24{byte_sel[7]}}, byte_sel};
      OpLbu:   load_value_o = {24'h0, byte_sel};
      OpLh:    load_value_o = {{16{half_sel[15]}}, half_sel};
      OpLhu:   load_value_o = {16'h0, half_sel};
      default: load_value_o = word_i;
    endcase

    store_word_o = word_i;
    if (op_i == OpSb) begin
      store_word_o[{addr_i, 3'b000} +: 8] = store_data_i[7:0];
    end else if (op_i == OpSh) begin
      store_word_o[{addr_i[1], 4'b0000} +: 16] = store_data_i;
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: runs one load/store per request against DataMemory; SB/SH use read-modify-write.
module load_store_unit
  import load_store_unit_pkg::*;
(
  input  logic               Clk,
  input  logic               Reset,
  load_store_unit_if.slave   bus
);

  state_e            state_q, state_d;
  logic [3:0]        op_q, op_d;
  logic [1:0]        lane_q, lane_d;
  logic [15:0]       sdata_q, sdata_d;
  logic [DATA_W-1:0] load_q, load_d;
  logic [ADDR_W-1:0] maddr_q, maddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              err_q, err_d;

  logic [DATA_W-1:0] lane_load;
  logic [DATA_W-1:0] lane_store;

  byte_lane_unit u_byte_lane_unit (
    .word_i       (bus.MemReadData),
    .addr_i       (lane_q),
    .op_i         (op_q),
    .store_data_i (sdata_q),
    .load_value_o (lane_load),
    .store_word_o (lane_store)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    lane_d  = lane_q;
    sdata_d = sdata_q;
    load_d  = load_q;
    maddr_d = maddr_q;
    wdata_d = wdata_q;
    err_d   = err_q;

    unique case (state_q)
      StIdle: begin
        if (bus.Start) begin
          op_d    = bus.Op;
          lane_d  = bus.Addr[1:0];
          sdata_d = bus.StoreData[15:0];
          maddr_d = {bus.Addr[ADDR_W-1:2], 2'b00};
          err_d   = 1'b0;
          if (!op_legal(bus.Op) || op_misaligned(bus.Op, bus.Addr[1:0])) begin
            // Rejected requests go straight to the response without touching memory.
            err_d   = 1'b1;
            state_d = StResp;
          end else if (!bus.Op[3]) begin
            state_d = StRead;
          end else if (bus.Op == OpSw) begin
            wdata_d = bus.StoreData;
            state_d = StWrite;
          end else begin
            state_d = StRmwRd;
          end
        end
      end
      StRead: begin
        load_d  = lane_load;
        state_d = StResp;
      end
      StRmwRd: begin
        wdata_d = lane_store;
        state_d = StWrite;
      end
      StWrite: state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= StIdle;
      op_q    <= '0;
      lane_q  <= '0;
      sdata_q <= '0;
      load_q  <= '0;
      maddr_q <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      lane_q  <= lane_d;
      sdata_q <= sdata_d;
      load_q  <= load_d;
      maddr_q <= maddr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

  assign bus.LoadData     = load_q;
  assign bus.MemAddress   = maddr_q;
  assign bus.MemWriteData = wdata_q;
  assign bus.Done         = (state_q == StResp);
  assign bus.Error        = (state_q == StResp) && err_q;
  assign bus.Busy         = (state_q != StIdle);
  assign bus.MemRead      = (state_q == StRead) || (state_q == StRmwRd);
  assign bus.MemWrite     = (state_q == StWrite);

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit against a word-array memory and a behavioural model.
module tb_load_store_unit;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic mem_clear = 1'b0;
  logic [31:0] mem [16];

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] ref_mem [16];
  logic [31:0] ref_load;

  load_store_unit_if bus ();

  load_store_unit dut (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign bus.MemReadData = mem[bus.MemAddress[5:2]];

  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 16; i++) mem[i] <= '0;
    end else if (bus.MemWrite) begin
      mem[bus.MemAddress[5:2]] <= bus.MemWriteData;
    end
  end

  // Directed sequence: op, address, store data, expected load value (loads only).
  logic [3:0]  d_op   [12] = '{4'h a, 4'h2, 4'h a, 4'h0, 4'h4, 4'h1, 4'h5, 4'h0,
                               4'h8, 4'h2, 4'h9, 4'h2};
  logic [31:0] d_addr [12] = '{0, 0, 4, 4, 4, 6, 6, 3, 5, 4, 0, 0};
  logic [31:0] d_sd   [12] = '{32'h12345678, 0, 32'hABCDEF98, 0, 0, 0, 0, 0,
                               32'h000000FF, 0, 32'h0000BEEF, 0};
  logic [31:0] d_exp  [12] = '{0, 32'h12345678, 0, 32'hFFFFFF98, 32'h00000098,
                               32'hFFFFABCD, 32'h0000ABCD, 32'h00000012, 0,
                               32'hABCDFF98, 0, 32'h1234BEEF};

  // Issue one request and watch the bus until Done (bounded).
  task automatic run_op(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sd,
                        output int lat, output int rd, output int wr, output bit both,
                        output bit busy_gap, output logic err, output logic [31:0] ld);
    @(negedge clk);
    bus.Start = 1'b1; bus.Op = op; bus.Addr = addr; bus.StoreData = sd;
    @(posedge clk);
    rd = 0; wr = 0; both = 0; busy_gap = 0; err = 1'bx; ld = 'x;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      bus.Start = 1'b0;
      lat = c;
      rd += int'(bus.MemRead);
      wr += int'(bus.MemWrite);
      if (bus.MemRead && bus.MemWrite) both = 1;
      if (bus.Busy !== 1'b1) busy_gap = 1;
      if (bus.Done === 1'b1) begin
        err = bus.Error;
        ld  = bus.LoadData;
        return;
      end
    end
    lat = 99;
  endtask

  // Behavioural reference: latency, memory traffic and results from the access rules.
  task automatic model_op(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sd,
                          output int lat, output int rd, output int wr, output logic err);
    int          idx = int'(addr[5:2]);
    int          sh  = 8 * int'(addr[1:0]);
    logic [31:0] w   = ref_mem[idx];
    logic [31:0] b   = (w >> sh) & 32'hFF;
    logic [31:0] h   = (w >> sh) & 32'hFFFF;
    int          size;
    bit          legal = 1;
    case (op)
      4'h0, 4'h4, 4'h8: size = 1;
      4'h1, 4'h5, 4'h9: size = 2;
      4'h2, 4'h a:      size = 4;
      default: begin size = 1; legal = 0; end
    endcase
    if (!legal || (addr % size) != 0) begin
      lat = 1; rd = 0; wr = 0; err = 1'b1;
      return;
    end
    err = 1'b0;
    if (op < 8) begin
      lat = 2; rd = 1; wr = 0;
      case (op)
        4'h0:    ref_load = (b >= 128) ? (b | 32'hFFFFFF00) : b;
        4'h4:    ref_load = b;
        4'h1:    ref_load = (h >= 32768) ? (h | 32'hFFFF0000) : h;
        4'h5:    ref_load = h;
        default: ref_load = w;
      endcase
    end else if (op == 4'h a) begin
      lat = 2; rd = 0; wr = 1;
      ref_mem[idx] = sd;
    end else begin
      lat = 3; rd = 1; wr = 1;
      if (size == 1) ref_mem[idx] = (w & ~(32'hFF << sh)) | ((sd & 32'hFF) << sh);
      else           ref_mem[idx] = (w & ~(32'hFFFF << sh)) | ((sd & 32'hFFFF) << sh);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; mem_clear = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if ({bus.LoadData, bus.MemAddress, bus.MemWriteData} !== 96'h0) begin
      n_fail++;
      $display("FAIL reset_words: got %0h %0h %0h required 0 0 0",
               bus.LoadData, bus.MemAddress, bus.MemWriteData);
    end
    n_tests++;
    if ({bus.Done, bus.Error, bus.Busy, bus.MemWrite, bus.MemRead} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b required 00000",
               {bus.Done, bus.Error, bus.Busy, bus.MemWrite, bus.MemRead});
    end
    rst = 1'b0; mem_clear = 1'b0;
    for (int i = 0; i < 16; i++) ref_mem[i] = '0;
    ref_load = '0;
  endtask

  task automatic test_directed();
    int lat, rd, wr, e_lat, e_rd, e_wr;
    bit both, gap;
    logic err, e_err;
    logic [31:0] ld;
    for (int i = 0; i < 12; i++) begin
      run_op(d_op[i], d_addr[i], d_sd[i], lat, rd, wr, both, gap, err, ld);
      model_op(d_op[i], d_addr[i], d_sd[i], e_lat, e_rd, e_wr, e_err);
      n_tests++;
      if (lat !== e_lat || rd !== e_rd || wr !== e_wr || err !== e_err || both || gap) begin
        n_fail++;
        $display("FAIL directed_%0d_bus: got lat=%0d rd=%0d wr=%0d err=%b both=%0d gap=%0d required lat=%0d rd=%0d wr=%0d err=%b both=0 gap=0",
                 i, lat, rd, wr, err, both, gap, e_lat, e_rd, e_wr, e_err);
      end
      if (d_op[i] < 8) begin
        n_tests++;
        if (ld !== d_exp[i]) begin
          n_fail++;
          $display("FAIL directed_%0d_load: got %08h required %08h", i, ld, d_exp[i]);
        end
      end
    end
  endtask

  task automatic test_errors();
    logic [3:0]  e_op   [3] = '{4'h9, 4'h2, 4'h3};
    logic [31:0] e_addr [3] = '{1, 2, 0};
    int lat, rd, wr;
    bit both, gap;
    logic err;
    logic [31:0] ld;
    for (int i = 0; i < 3; i++) begin
      run_op(e_op[i], e_addr[i], 32'hDEADBEEF, lat, rd, wr, both, gap, err, ld);
      n_tests++;
      if (lat !== 1 || rd !== 0 || wr !== 0 || err !== 1'b1 || ld !== 32'h1234BEEF) begin
        n_fail++;
        $display("FAIL error_%0d: got lat=%0d rd=%0d wr=%0d err=%b ld=%08h required lat=1 rd=0 wr=0 err=1 ld=1234beef",
                 i, lat, rd, wr, err, ld);
      end
    end
    n_tests++;
    if (mem[0] !== 32'h1234BEEF || mem[1] !== 32'hABCDFF98) begin
      n_fail++;
      $display("FAIL error_mem: got %08h %08h required 1234beef abcdff98", mem[0], mem[1]);
    end
  endtask

  task automatic test_busy_start();
    int e_lat, e_rd, e_wr, dones = 0;
    logic e_err;
    model_op(4'h8, 32'd5, 32'h11, e_lat, e_rd, e_wr, e_err);
    @(negedge clk);
    bus.Start = 1'b1; bus.Op = 4'h8; bus.Addr = 32'd5; bus.StoreData = 32'h11;
    @(posedge clk);
    @(negedge clk);
    bus.Op = 4'h a; bus.Addr = 32'd0; bus.StoreData = 32'hCAFEF00D;
    for (int c = 0; c < 8; c++) begin
      if (bus.Done === 1'b1) begin
        dones++;
        bus.Start = 1'b0;
      end
      @(negedge clk);
    end
    bus.Start = 1'b0;
    n_tests++;
    if (dones !== 1) begin
      n_fail++;
      $display("FAIL busy_start_dones: got %0d required 1", dones);
    end
    n_tests++;
    if (mem[0] !== ref_mem[0] || mem[1] !== ref_mem[1]) begin
      n_fail++;
      $display("FAIL busy_start_mem: got %08h %08h required %08h %08h",
               mem[0], mem[1], ref_mem[0], ref_mem[1]);
    end
  endtask

  task automatic test_random();
    logic [3:0] legal_ops [8] = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h5, 4'h8, 4'h9, 4'h a};
    int lat, rd, wr, e_lat, e_rd, e_wr;
    bit both, gap;
    logic err, e_err;
    logic [31:0] ld, addr, sd;
    logic [3:0] op;
    for (int i = 0; i < 60; i++) begin
      int r = int'($urandom_range(0, 9));
      op   = (r < 8) ? legal_ops[r] : 4'($urandom_range(0, 15));
      addr = 32'($urandom_range(0, 63));
      sd   = $urandom;
      run_op(op, addr, sd, lat, rd, wr, both, gap, err, ld);
      model_op(op, addr, sd, e_lat, e_rd, e_wr, e_err);
      n_tests++;
      if (lat !== e_lat || rd !== e_rd || wr !== e_wr || err !== e_err || both || gap ||
          ld !== ref_load) begin
        n_fail++;
        $display("FAIL random_%0d op=%h addr=%0d: got lat=%0d rd=%0d wr=%0d err=%b both=%0d gap=%0d ld=%08h required lat=%0d rd=%0d wr=%0d err=%b ld=%08h",
                 i, op, addr, lat, rd, wr, err, both, gap, ld, e_lat, e_rd, e_wr, e_err, ref_load);
      end
    end
    n_tests++;
    if (mem != ref_mem) begin
      n_fail++;
      $display("FAIL random_mem: memory image differs from reference, word2 got %08h required %08h",
               mem[2], ref_mem[2]);
    end
  endtask

  task automatic test_reset_mid_op();
    int lat, rd, wr, e_lat, e_rd, e_wr;
    bit both, gap;
    logic err, e_err;
    logic [31:0] ld;
    run_op(4'h a, 32'd8, 32'hFFFFFFFF, lat, rd, wr, both, gap, err, ld);
    model_op(4'h a, 32'd8, 32'hFFFFFFFF, e_lat, e_rd, e_wr, e_err);
    @(negedge clk);
    bus.Start = 1'b1; bus.Op = 4'h8; bus.Addr = 32'd8; bus.StoreData = 32'h0;
    @(posedge clk);
    @(negedge clk);
    bus.Start = 1'b0;
    n_tests++;
    if (bus.MemRead !== 1'b1 || bus.Busy !== 1'b1) begin
      n_fail++;
      $display("FAIL midop_in_rmw: got rd=%b busy=%b required 1 1", bus.MemRead, bus.Busy);
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_tests++;
    if ({bus.Done, bus.Error, bus.Busy, bus.MemWrite, bus.MemRead} !== 5'b0 ||
        {bus.LoadData, bus.MemAddress, bus.MemWriteData} !== 96'h0) begin
      n_fail++;
      $display("FAIL midop_reset_outputs: got flags=%b words=%0h %0h %0h required 0",
               {bus.Done, bus.Error, bus.Busy, bus.MemWrite, bus.MemRead},
               bus.LoadData, bus.MemAddress, bus.MemWriteData);
    end
    rst = 1'b0;
    ref_load = '0;
    run_op(4'h2, 32'd8, 32'h0, lat, rd, wr, both, gap, err, ld);
    model_op(4'h2, 32'd8, 32'h0, e_lat, e_rd, e_wr, e_err);
    n_tests++;
    if (ld !== 32'hFFFFFFFF || err !== 1'b0 || lat !== 2) begin
      n_fail++;
      $display("FAIL midop_lw8: got ld=%08h err=%b lat=%0d required ffffffff 0 2", ld, err, lat);
    end
  endtask

  task automatic test_reset_start();
    @(negedge clk);
    rst = 1'b1; bus.Start = 1'b1; bus.Op = 4'h2; bus.Addr = 32'd0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; bus.Start = 1'b0;
    n_tests++;
    if (bus.Busy !== 1'b0 || bus.Done !== 1'b0 || bus.LoadData !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_start_0: got busy=%b done=%b ld=%08h required 0 0 0",
               bus.Busy, bus.Done, bus.LoadData);
    end
    @(negedge clk);
    n_tests++;
    if (bus.Busy !== 1'b0 || bus.MemRead !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_start_1: got busy=%b rd=%b required 0 0", bus.Busy, bus.MemRead);
    end
  endtask

  initial begin
    bus.Start = 1'b0; bus.Op = '0; bus.Addr = '0; bus.StoreData = '0;
    test_reset();
    test_directed();
    test_errors();
    test_busy_start();
    test_random();
    test_reset_mid_op();
    test_reset_start();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
